msp430_seq_ctrl: RTL and testbench

Parametrised multi-cycle sequencer for the MSP430x2xx core. It replaces the fixed control FSM behind the top-level Fsm/PC_inc_out/Wr_en_out debug outputs. Adds a program-load hold state, a memory ready/timeout handshake, immediate-operand fetch, jump condition evaluation, and a sticky trap state for unsupported encodings. It drives register-file, ALU and PC control; the register file, ALU and memory remain in their own blocks.

---
 rtl/msp430_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_msp430_seq_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msp430_seq_ctrl.sv
// msp430_seq_ctrl: multi-cycle control sequencer for the MSP430x2xx core.
// Define MSP430_SINGLE_STEP_EN to add the Step input and the HOLD state.
module msp430_seq_ctrl #(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 4,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Load_en,
`ifdef MSP430_SINGLE_STEP_EN
    input  logic              Step,
`endif
    input  logic [DATA_W-1:0] Mem_data,
    input  logic              Mem_ready,
    input  logic [3:0]        Flags_in,
    output logic              Mem_rd,
    output logic [DATA_W-1:0] Instr,
    output logic [DATA_W-1:0] Imm,
    output logic [REG_AW-1:0] Src_reg,
    output logic [REG_AW-1:0] Dst_reg,
    output logic [3:0]        Alu_op,
    output logic              Bw,
    output logic              PC_inc,
    output logic              Wr_en,
    output logic              Flags_wr,
    output logic              Jmp_en,
    output logic              Trap,
    output logic [4:0]        Fsm
);
    localparam logic [4:0] S_RESET  = 5'd0;
    localparam logic [4:0] S_LOAD   = 5'd1;
    localparam logic [4:0] S_FETCH  = 5'd2;
    localparam logic [4:0] S_DECODE = 5'd3;
    localparam logic [4:0] S_IMM    = 5'd4;
    localparam logic [4:0] S_EXEC   = 5'd5;
    localparam logic [4:0] S_WB     = 5'd6;
    localparam logic [4:0] S_JUMP   = 5'd7;
    localparam logic [4:0] S_TRAP   = 5'd8;
`ifdef MSP430_SINGLE_STEP_EN
    localparam logic [4:0] S_HOLD   = 5'd9;
`endif

    logic [4:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] instr_q, instr_d, imm_q, imm_d;
    logic [REG_AW-1:0] src_q, src_d, dst_q, dst_d;
    logic [3:0]        op_q, op_d;
    logic              bw_q, bw_d;
    logic [15:0]       ir;
    logic              fmt1, fmt2, jump, wait_st, timeout, taken, nv;
    logic [4:0]        done_st;
    logic [7:0]        conds;

    assign ir = instr_q[15:0];

    always_comb begin
        fmt1    = ir[15:12] >= 4'd4;
        fmt2    = ir[15:10] == 6'b000100 && ir[9:7] <= 3'd3 && ir[5:4] == 2'b00;
        jump    = ir[15:13] == 3'b001;
        nv      = Flags_in[2] ^ Flags_in[3];
        // Jump condition table indexed by Ir[12:10]
        conds   = {1'b1, nv, ~nv, Flags_in[2], Flags_in[0], ~Flags_in[0], Flags_in[1], ~Flags_in[1]};
        taken   = conds[ir[12:10]];
        wait_st = state_q == S_FETCH || state_q == S_IMM;
        timeout = cnt_q == CNT_W'(TIMEOUT - 1);
`ifdef MSP430_SINGLE_STEP_EN
        done_st = Load_en ? S_LOAD : S_HOLD;
`else
        done_st = Load_en ? S_LOAD : S_FETCH;
`endif
        state_d = state_q;
        case (state_q)
            S_RESET, S_LOAD: state_d = Load_en ? S_LOAD : S_FETCH;
            S_FETCH, S_IMM:  state_d = Mem_ready ? (state_q == S_FETCH ? S_DECODE : S_EXEC)
                                                 : (timeout ? S_TRAP : state_q);
            S_DECODE:        state_d = fmt1 ? (ir[5:4] == 2'b00 ? S_EXEC :
                                               (ir[5:4] == 2'b11 && ir[11:8] == 4'd0) ? S_IMM : S_TRAP)
                                            : fmt2 ? S_EXEC : jump ? S_JUMP : S_TRAP;
            S_EXEC:          state_d = S_WB;
            S_WB, S_JUMP:    state_d = done_st;
            S_TRAP:          state_d = Load_en ? S_LOAD : S_TRAP;
`ifdef MSP430_SINGLE_STEP_EN
            S_HOLD:          state_d = Load_en ? S_LOAD : Step ? S_FETCH : S_HOLD;
`endif
            default:         state_d = S_TRAP;
        endcase
        // Ready on the timeout cycle still captures; counter idles at zero elsewhere
        cnt_d   = (wait_st && !Mem_ready && !timeout) ? cnt_q + 1'b1 : '0;
        instr_d = (state_q == S_FETCH && Mem_ready) ? Mem_data : instr_q;
        imm_d   = (state_q == S_IMM && Mem_ready) ? Mem_data : imm_q;
        src_d   = state_q == S_DECODE ? REG_AW'(ir[11:8]) : src_q;
        dst_d   = state_q == S_DECODE ? REG_AW'(ir[3:0]) : dst_q;
        op_d    = state_q == S_DECODE ? (fmt1 ? ir[15:12] : {1'b0, ir[9:7]}) : op_q;
        bw_d    = state_q == S_DECODE ? ir[6] : bw_q;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            instr_q <= '0;
            imm_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            op_q    <= '0;
            bw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            imm_q   <= imm_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            op_q    <= op_d;
            bw_q    <= bw_d;
        end
    end

    // Format II ops only reach 0..3, so op 1 here is always SWPB
    assign Flags_wr = state_q == S_EXEC && !(op_q inside {4'h1, 4'h4, 4'hC, 4'hD});
    assign Wr_en    = state_q == S_WB && op_q != 4'h9 && op_q != 4'hB;
    assign Jmp_en   = state_q == S_JUMP && taken;
    assign Trap     = state_q == S_TRAP;
    assign Mem_rd   = wait_st;
    assign PC_inc   = wait_st && Mem_ready;
    assign Fsm      = state_q;
    assign Instr    = instr_q;
    assign Imm      = imm_q;
    assign Src_reg  = src_q;
    assign Dst_reg  = dst_q;
    assign Alu_op   = op_q;
    assign Bw       = bw_q;
endmodule

// File: tb/tb_msp430_seq_ctrl.sv
// tb_msp430_seq_ctrl: table-driven, hand-sequenced and randomized checks of msp430_seq_ctrl.
module tb_msp430_seq_ctrl;
    localparam int TIMEOUT = 8;

    typedef struct {
        logic [15:0] ins;
        logic [15:0] imm;
        logic [3:0]  flg;
        logic [4:0]  path;
        logic [3:0]  op;
        logic        fw;
        logic        we;
        logic        jmp;
    } vec_t;

    logic        Clk = 1'b0;
    logic        Rst, Load_en, Mem_ready;
    logic [15:0] Mem_data;
    logic [3:0]  Flags_in;
    logic        Mem_rd, Bw, PC_inc, Wr_en, Flags_wr, Jmp_en, Trap;
    logic [15:0] Instr, Imm;
    logic [3:0]  Src_reg, Dst_reg, Alu_op;
    logic [4:0]  Fsm;
`ifdef MSP430_SINGLE_STEP_EN
    logic        Step;
    int          n_hold = 0;
`endif
    int          n_cmp = 0;
    int          n_bad = 0;
    vec_t        tbl[$];
    vec_t        v;
    logic [15:0] rnd, ins;
    logic [3:0]  op4;

    always #5 Clk = ~Clk;

    msp430_seq_ctrl #(.DATA_W(16), .REG_AW(4), .TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .Clk(Clk), .Rst(Rst), .Load_en(Load_en),
`ifdef MSP430_SINGLE_STEP_EN
        .Step(Step),
`endif
        .Mem_data(Mem_data), .Mem_ready(Mem_ready), .Flags_in(Flags_in),
        .Mem_rd(Mem_rd), .Instr(Instr), .Imm(Imm), .Src_reg(Src_reg), .Dst_reg(Dst_reg),
        .Alu_op(Alu_op), .Bw(Bw), .PC_inc(PC_inc), .Wr_en(Wr_en), .Flags_wr(Flags_wr),
        .Jmp_en(Jmp_en), .Trap(Trap), .Fsm(Fsm)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic neg();
        @(negedge Clk);
        chk("excl_pulses", 32'($countones({PC_inc, Jmp_en, Wr_en, Flags_wr}) > 1), 0);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {Mem_rd, PC_inc, Wr_en, Flags_wr, Jmp_en, Trap, Bw}, 0);
        chk({tag, "_fsm"}, Fsm, 0);
        chk({tag, "_instr"}, Instr, 0);
        chk({tag, "_imm"}, Imm, 0);
        chk({tag, "_regs"}, {Src_reg, Dst_reg, Alu_op}, 0);
    endtask

    function automatic vec_t mk(input logic [15:0] i, input logic [15:0] m, input logic [3:0] f,
                                input logic [4:0] p, input logic [3:0] o, input logic fw,
                                input logic we, input logic jm);
        vec_t r;
        r.ins = i; r.imm = m; r.flg = f; r.path = p; r.op = o; r.fw = fw; r.we = we; r.jmp = jm;
        return r;
    endfunction

    // Reference model: expected path and control outcome for one whole instruction
    function automatic vec_t model(input logic [15:0] i, input logic [15:0] m, input logic [3:0] f);
        vec_t r;
        int opc = int'(i >> 12);
        int as  = int'((i >> 4) & 16'd3);
        int sub = int'((i >> 7) & 16'd7);
        int cc  = int'((i >> 10) & 16'd7);
        bit f2  = (i >> 10) == 16'd4 && sub <= 3 && as == 0;
        r = mk(i, m, f, 5'd8, 4'd0, 1'b0, 1'b0, 1'b0);
        if (opc >= 4) begin
            r.op = 4'(opc);
            if (as == 0) r.path = 5'd5;
            else if (as == 3 && ((i >> 8) & 16'd15) == 0) r.path = 5'd4;
        end else if (f2) begin
            r.op = 4'(sub);
            r.path = 5'd5;
        end else if (opc == 2 || opc == 3) begin
            r.path = 5'd7;
            case (cc)
                0: r.jmp = !f[1];
                1: r.jmp = f[1];
                2: r.jmp = !f[0];
                3: r.jmp = f[0];
                4: r.jmp = f[2];
                5: r.jmp = f[2] == f[3];
                6: r.jmp = f[2] != f[3];
                default: r.jmp = 1'b1;
            endcase
        end
        r.fw = !(opc == 4 || opc == 12 || opc == 13 || (f2 && sub == 1));
        r.we = !(opc == 9 || opc == 11);
        return r;
    endfunction

    task automatic fetch_word(input logic [15:0] w, input int waits, input logic [4:0] st);
        Mem_ready = 1'b0;
        for (int i = 0; i < waits; i++) begin
            Mem_data = 16'($urandom);
            neg();
            chk("wait_fsm", Fsm, st);
            chk("wait_rd", Mem_rd, 1);
            chk("wait_pcinc", PC_inc, 0);
            tick();
        end
        Mem_ready = 1'b1;
        Mem_data = w;
        neg();
        chk("cap_fsm", Fsm, st);
        chk("cap_pcinc", PC_inc, 1);
        tick();
        Mem_ready = 1'b0;
        Mem_data = 16'($urandom);
    endtask

    task automatic wrap_up(input bit le);
        if (le) begin
            Load_en = 1'b0;
            neg();
            chk("load_after", Fsm, 1);
            tick();
        end else begin
`ifdef MSP430_SINGLE_STEP_EN
            neg();
            chk("hold_fsm", Fsm, 9);
            chk("hold_quiet", {Mem_rd, PC_inc, Wr_en, Flags_wr, Jmp_en, Trap}, 0);
            tick();
            n_hold++;
            Step = 1'b1;
            Load_en = n_hold[0];
            neg();
            chk("hold_step", Fsm, 9);
            tick();
            Step = 1'b0;
            if (Load_en) begin
                Load_en = 1'b0;
                neg();
                chk("hold_load", Fsm, 1);
                tick();
            end
`endif
        end
    endtask

    task automatic run_instr(input vec_t x, input int w1, input int w2, input bit le);
        Flags_in = x.flg;
        Load_en = le;
        fetch_word(x.ins, w1, 5'd2);
        neg();
        chk("dec_fsm", Fsm, 3);
        chk("instr", Instr, x.ins);
        chk("dec_rd", Mem_rd, 0);
        tick();
        if (x.path == 5'd4) fetch_word(x.imm, w2, 5'd4);
        if (x.path == 5'd4 || x.path == 5'd5) begin
            neg();
            chk("exec_fsm", Fsm, 5);
            chk("flags_wr", Flags_wr, x.fw);
            chk("src", Src_reg, x.ins[11:8]);
            chk("dst", Dst_reg, x.ins[3:0]);
            chk("alu_op", Alu_op, x.op);
            chk("bw", Bw, x.ins[6]);
            if (x.path == 5'd4) chk("imm", Imm, x.imm);
            tick();
            neg();
            chk("wb_fsm", Fsm, 6);
            chk("wr_en", Wr_en, x.we);
            tick();
            wrap_up(le);
        end else if (x.path == 5'd7) begin
            neg();
            chk("jmp_fsm", Fsm, 7);
            chk("jmp_en", Jmp_en, x.jmp);
            tick();
            wrap_up(le);
        end else begin
            neg();
            chk("trap_fsm", Fsm, 8);
            chk("trap", {Trap, Mem_rd}, 2'b10);
            tick();
            if (!le) begin
                neg();
                chk("trap_sticky", Fsm, 8);
                tick();
                Load_en = 1'b1;
                neg();
                chk("trap_exit_wait", Fsm, 8);
                tick();
            end
            Load_en = 1'b0;
            neg();
            chk("trap_to_load", Fsm, 1);
            tick();
        end
    endtask

    task automatic timeout_test(input bit in_imm);
        logic [4:0] st = in_imm ? 5'd4 : 5'd2;
        Load_en = 1'b0;
        if (in_imm) begin
            fetch_word(16'h4035, 0, 5'd2);
            neg();
            chk("to_dec", Fsm, 3);
            tick();
        end
        Mem_ready = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            neg();
            chk("to_wait", Fsm, st);
            chk("to_rd", Mem_rd, 1);
            tick();
        end
        neg();
        chk("to_trap_fsm", Fsm, 8);
        chk("to_trap", Trap, 1);
        tick();
        Load_en = 1'b1;
        neg();
        chk("to_trap_hold", Fsm, 8);
        tick();
        Load_en = 1'b0;
        neg();
        chk("to_load", Fsm, 1);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Rst = 1'b0; Load_en = 1'b0; Mem_ready = 1'b0; Mem_data = '0; Flags_in = '0;
`ifdef MSP430_SINGLE_STEP_EN
        Step = 1'b0;
`endif
        tbl.push_back(mk(16'h5405, 16'h0000, 4'h0, 5'd5, 4'h5, 1, 1, 0));
        tbl.push_back(mk(16'h5445, 16'h0000, 4'h0, 5'd5, 4'h5, 1, 1, 0));
        tbl.push_back(mk(16'h4035, 16'h1234, 4'h0, 5'd4, 4'h4, 0, 1, 0));
        tbl.push_back(mk(16'h5035, 16'hBEEF, 4'h0, 5'd4, 4'h5, 1, 1, 0));
        tbl.push_back(mk(16'h9405, 16'h0000, 4'h0, 5'd5, 4'h9, 1, 0, 0));
        tbl.push_back(mk(16'hB405, 16'h0000, 4'h0, 5'd5, 4'hB, 1, 0, 0));
        tbl.push_back(mk(16'hC405, 16'h0000, 4'h0, 5'd5, 4'hC, 0, 1, 0));
        tbl.push_back(mk(16'hD405, 16'h0000, 4'h0, 5'd5, 4'hD, 0, 1, 0));
        tbl.push_back(mk(16'h8405, 16'h0000, 4'h0, 5'd5, 4'h8, 1, 1, 0));
        tbl.push_back(mk(16'hF405, 16'h0000, 4'h0, 5'd5, 4'hF, 1, 1, 0));
        tbl.push_back(mk(16'h4405, 16'h0000, 4'h0, 5'd5, 4'h4, 0, 1, 0));
        tbl.push_back(mk(16'h1085, 16'h0000, 4'h0, 5'd5, 4'h1, 0, 1, 0));
        tbl.push_back(mk(16'h1005, 16'h0000, 4'h0, 5'd5, 4'h0, 1, 1, 0));
        tbl.push_back(mk(16'h11C5, 16'h0000, 4'h0, 5'd5, 4'h3, 1, 1, 0));
        tbl.push_back(mk(16'h0000, 16'h0000, 4'h0, 5'd8, 4'h0, 0, 0, 0));
        tbl.push_back(mk(16'h1205, 16'h0000, 4'h0, 5'd8, 4'h0, 0, 0, 0));
        tbl.push_back(mk(16'h1015, 16'h0000, 4'h0, 5'd8, 4'h0, 0, 0, 0));
        tbl.push_back(mk(16'h4015, 16'h0000, 4'h0, 5'd8, 4'h0, 0, 0, 0));
        tbl.push_back(mk(16'h4135, 16'h0000, 4'h0, 5'd8, 4'h0, 0, 0, 0));
        tbl.push_back(mk(16'h2405, 16'h0000, 4'h2, 5'd7, 4'h0, 0, 0, 1));
        tbl.push_back(mk(16'h2405, 16'h0000, 4'h0, 5'd7, 4'h0, 0, 0, 0));
        tbl.push_back(mk(16'h2000, 16'h0000, 4'h2, 5'd7, 4'h0, 0, 0, 0));
        tbl.push_back(mk(16'h2000, 16'h0000, 4'h0, 5'd7, 4'h0, 0, 0, 1));
        tbl.push_back(mk(16'h2800, 16'h0000, 4'h1, 5'd7, 4'h0, 0, 0, 0));
        tbl.push_back(mk(16'h2C00, 16'h0000, 4'h1, 5'd7, 4'h0, 0, 0, 1));
        tbl.push_back(mk(16'h3000, 16'h0000, 4'h4, 5'd7, 4'h0, 0, 0, 1));
        tbl.push_back(mk(16'h3000, 16'h0000, 4'h0, 5'd7, 4'h0, 0, 0, 0));
        tbl.push_back(mk(16'h3400, 16'h0000, 4'hC, 5'd7, 4'h0, 0, 0, 1));
        tbl.push_back(mk(16'h3400, 16'h0000, 4'h4, 5'd7, 4'h0, 0, 0, 0));
        tbl.push_back(mk(16'h3800, 16'h0000, 4'h8, 5'd7, 4'h0, 0, 0, 1));
        tbl.push_back(mk(16'h3800, 16'h0000, 4'h0, 5'd7, 4'h0, 0, 0, 0));
        tbl.push_back(mk(16'h3C00, 16'h0000, 4'h0, 5'd7, 4'h0, 0, 0, 1));

        neg();
        chk_zero("reset");
        tick();
        Load_en = 1'b1;
        Rst = 1'b1;
        neg();
        chk("rst_release", Fsm, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("load_hold", Fsm, 1);
            chk("load_quiet", {Mem_rd, PC_inc, Wr_en, Flags_wr, Jmp_en, Trap}, 0);
            tick();
        end
        Load_en = 1'b0;
        neg();
        chk("load_exit", Fsm, 1);
        tick();

        foreach (tbl[i]) run_instr(tbl[i], i % TIMEOUT, (i * 3) % TIMEOUT, i % 5 == 4);

        timeout_test(1'b0);
        timeout_test(1'b1);

        Mem_ready = 1'b0;
        neg();
        chk("pre_rst_rd", Mem_rd, 1);
        #1 Rst = 1'b0;
        Load_en = 1'b1;
        neg();
        chk_zero("mid_rst");
        tick();
        Rst = 1'b1;
        neg();
        chk("mid_rst_release", Fsm, 0);
        tick();
        neg();
        chk("mid_rst_load", Fsm, 1);
        tick();
        Load_en = 1'b0;
        neg();
        chk("mid_rst_load2", Fsm, 1);
        tick();

        for (int k = 0; k < 300; k++) begin
            rnd = 16'($urandom);
            op4 = 4'($urandom_range(4, 15));
            case ($urandom_range(0, 5))
                0: ins = rnd;
                1: ins = {op4, 4'h0, rnd[7:6], 2'b11, rnd[3:0]};
                2: ins = {op4, rnd[11:6], 2'b00, rnd[3:0]};
                3: ins = {6'b000100, rnd[9:0]};
                4: ins = {3'b001, rnd[12:0]};
                default: ins = {3'b000, rnd[12:0]};
            endcase
            v = model(ins, 16'($urandom), 4'($urandom));
            run_instr(v, int'($urandom_range(0, TIMEOUT - 1)), int'($urandom_range(0, TIMEOUT - 1)),
                      $urandom_range(0, 7) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
